// File: rtl/lsu.sv
// Load/store unit: turns one memory instruction into one handshaked bus transaction.
// Sub-word (B/H/BU/HU) lane handling and misalignment checks exist only when LSU_SUBWORD_EN is defined.
module lsu #(
  parameter int WIDTH = 32,
  parameter int DADDR = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [DADDR-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             stall,
  output logic             err,
  output logic             bus_valid,
  input  logic             bus_ready,
  output logic             bus_we,
  output logic [DADDR-1:0] bus_addr,
  output logic [3:0]       bus_be,
  output logic [WIDTH-1:0] bus_wdata,
  input  logic             bus_rvalid,
  input  logic [WIDTH-1:0] bus_rdata
);

  // state | meaning
  // IDLE  | waiting for a memory instruction; err reported here
  // REQ   | bus_valid high, request fields held until bus_ready
  // WAIT  | load accepted, waiting for bus_rvalid
  // DONE  | one unstalled cycle so the core retires
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t           state, state_nxt;
  logic             legal;
  logic [3:0]       be_c;
  logic [WIDTH-1:0] wdata_c;
  logic [DADDR-1:0] addr_c;
  logic [WIDTH-1:0] load_c;

  assign addr_c = {req_addr[DADDR-1:2], 2'b00};

`ifdef LSU_SUBWORD_EN
  logic [2:0] f3_q;
  logic [1:0] lane_q;
  logic [7:0] byte_l;
  logic [15:0] half_l;

  always_comb begin
    legal   = 1'b0;
    be_c    = 4'b1111;
    wdata_c = req_wdata;
    case (req_funct3)
      3'b000, 3'b100: legal = 1'b1;
      3'b001, 3'b101: legal = ~req_addr[0];
      3'b010:         legal = (req_addr[1:0] == 2'b00);
      default:        legal = 1'b0;
    endcase
    case (req_funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << req_addr[1:0];
        wdata_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_c    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{req_wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = req_wdata;
      end
    endcase
  end

  // funct3 and lane are captured with the request so extraction never depends on req_* later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f3_q   <= 3'b000;
      lane_q <= 2'b00;
    end else if (state == IDLE && req_valid && legal) begin
      f3_q   <= req_funct3;
      lane_q <= req_addr[1:0];
    end
  end

  assign byte_l = bus_rdata[{lane_q, 3'b000} +: 8];
  assign half_l = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    load_c = bus_rdata;
    case (f3_q)
      3'b000:  load_c = {{24{byte_l[7]}}, byte_l};
      3'b100:  load_c = {24'h0, byte_l};
      3'b001:  load_c = {{16{half_l[15]}}, half_l};
      3'b101:  load_c = {16'h0, half_l};
      default: load_c = bus_rdata;
    endcase
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{req_funct3, req_addr[1:0]};
  assign legal   = 1'b1;
  assign be_c    = 4'b1111;
  assign wdata_c = req_wdata;
  assign load_c  = bus_rdata;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rdata     <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= 4'b0000;
      bus_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid && legal) begin
        bus_we    <= req_we;
        bus_addr  <= addr_c;
        bus_be    <= be_c;
        bus_wdata <= wdata_c;
      end
      if (state == WAIT && bus_rvalid)
        rdata <= load_c;
    end
  end

  assign bus_valid = (state == REQ);

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (legal) begin
            stall     = 1'b1;
            state_nxt = REQ;
          end else begin
            err = 1'b1;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus_ready)
          state_nxt = bus_we ? DONE : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (bus_rvalid)
          state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule
